qp_req_arbiter: RTL and testbench

- Shares one quick_page allocator request port among NUM_CLI requesters: dealloc from LSUs, alloc from host/DMA.
- Round-robin arbitration over valid/ready client channels.
- Drives the allocator's toggle-id request protocol and tracks its busy/reply handshake.
- Returns the reply (object descriptor plus error flag) to the granted client only.

---
 rtl/qp_req_arbiter.sv | 170 +++++++++++++++++
 tb/tb_qp_req_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qp_req_arbiter.sv
// Round-robin arbiter sharing one quick_page allocator request port.
// Drives the toggle-id request protocol and routes the reply to the grantee.
module qp_req_arbiter #(
    parameter int NUM_CLI  = 4,
    parameter int CLI_W    = $clog2(NUM_CLI),
    parameter int REQ_W    = 6,
    parameter int REP_W    = 10,
    parameter int START_TO = 8
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [NUM_CLI-1:0]       i_cli_req_vld,
    output logic [NUM_CLI-1:0]       o_cli_req_rdy,
    input  logic [2*NUM_CLI-1:0]     i_cli_req_func,
    input  logic [REQ_W*NUM_CLI-1:0] i_cli_req_size,
    input  logic [REP_W*NUM_CLI-1:0] i_cli_req_data,
    output logic [NUM_CLI-1:0]       o_cli_rsp_vld,
    output logic                     o_cli_rsp_err,
    output logic [REP_W-1:0]         o_cli_rsp_data,
    output logic                     o_req_id,
    output logic [1:0]               o_req_func,
    output logic [REQ_W-1:0]         o_req_alloc_size,
    output logic [REP_W-1:0]         o_req_dealloc_data,
    input  logic                     i_busy,
    input  logic                     i_rep_alloc_vld,
    input  logic                     i_rep_dealloc_vld,
    input  logic [REP_W-1:0]         i_rep_data,
    output logic                     o_idle
);

    localparam int CNT_W = $clog2(START_TO + 1);
    localparam logic [REQ_W-1:0] MAX_SIZE = REQ_W'(1) << (REQ_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BSY,
        WAIT_DONE,
        RESP
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CLI_W-1:0]   ptr;
    logic [CLI_W-1:0]   grant;
    logic [CLI_W-1:0]   win_idx;
    logic [CLI_W-1:0]   scan [NUM_CLI];
    logic               win_any;
    logic [1:0]         win_func;
    logic [REQ_W-1:0]   win_size;
    logic [REP_W-1:0]   win_data;
    logic               accept;
    logic               reject;
    logic               strobe;
    logic               in_op;
    logic               timeout;
    logic               done;
    logic               ok_flag;
    logic               alloc_op;
    logic [CNT_W-1:0]   cnt;

    for (genvar g = 0; g < NUM_CLI; g++) begin : g_scan
        assign scan[g] = CLI_W'((int'(ptr) + g) % NUM_CLI);
    end

    // First requester at or after the pointer wins.
    always_comb begin
        win_any = 1'b0;
        win_idx = '0;
        for (int i = 0; i < NUM_CLI; i++) begin
            if (!win_any && i_cli_req_vld[scan[i]]) begin
                win_any = 1'b1;
                win_idx = scan[i];
            end
        end
    end

    assign win_func = i_cli_req_func[int'(win_idx)*2 +: 2];
    assign win_size = i_cli_req_size[int'(win_idx)*REQ_W +: REQ_W];
    assign win_data = i_cli_req_data[int'(win_idx)*REP_W +: REP_W];

    assign reject = (win_func == 2'b00) || (win_func == 2'b11) ||
                    ((win_func == 2'b01) &&
                     ((win_size == '0) || (win_size > MAX_SIZE)));

    assign accept  = (state == IDLE) && win_any;
    assign o_cli_req_rdy = accept ? (NUM_CLI'(1) << win_idx) : '0;
    assign o_idle  = (state == IDLE) && !(|i_cli_req_vld);

    assign strobe  = alloc_op ? i_rep_alloc_vld : i_rep_dealloc_vld;
    assign in_op   = (state == ISSUE) || (state == WAIT_BSY) ||
                     (state == WAIT_DONE);
    assign timeout = (state == WAIT_BSY) && !i_busy && (cnt == CNT_W'(1));
    assign done    = (state == WAIT_DONE) && !i_busy;

    always_ff @(posedge i_clk) begin
        if (i_reset) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:      if (accept) state_nxt = reject ? RESP : ISSUE;
            ISSUE:     state_nxt = WAIT_BSY;
            WAIT_BSY:  begin
                if (i_busy)       state_nxt = WAIT_DONE;
                else if (timeout) state_nxt = RESP;
            end
            WAIT_DONE: if (!i_busy) state_nxt = RESP;
            RESP:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ptr                <= '0;
            grant              <= '0;
            cnt                <= '0;
            ok_flag            <= 1'b0;
            alloc_op           <= 1'b0;
            o_cli_rsp_vld      <= '0;
            o_cli_rsp_err      <= 1'b0;
            o_cli_rsp_data     <= '0;
            o_req_id           <= 1'b0;
            o_req_func         <= 2'b00;
            o_req_alloc_size   <= '0;
            o_req_dealloc_data <= '0;
        end else begin
            o_cli_rsp_vld <= '0;
            if (accept) begin
                grant    <= win_idx;
                ptr      <= (int'(win_idx) == NUM_CLI - 1) ? '0 : win_idx + 1'b1;
                ok_flag  <= 1'b0;
                alloc_op <= (win_func == 2'b01);
                if (reject) begin
                    o_cli_rsp_vld  <= NUM_CLI'(1) << win_idx;
                    o_cli_rsp_err  <= 1'b1;
                    o_cli_rsp_data <= '0;
                end else begin
                    o_req_id           <= ~o_req_id;
                    o_req_func         <= win_func;
                    o_req_alloc_size   <= win_size;
                    o_req_dealloc_data <= win_data;
                end
            end
            if (state == ISSUE)
                cnt <= CNT_W'(START_TO);
            else if ((state == WAIT_BSY) && !i_busy)
                cnt <= cnt - 1'b1;
            if (in_op && strobe)
                ok_flag <= 1'b1;
            if (timeout) begin
                o_cli_rsp_vld  <= NUM_CLI'(1) << grant;
                o_cli_rsp_err  <= 1'b1;
                o_cli_rsp_data <= '0;
                o_req_func     <= 2'b00;
            end
            // The success strobe may coincide with the busy-fall cycle.
            if (done) begin
                o_cli_rsp_vld  <= NUM_CLI'(1) << grant;
                o_cli_rsp_err  <= ~(ok_flag | strobe);
                o_cli_rsp_data <= i_rep_data;
                o_req_func     <= 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_qp_req_arbiter.sv
// Directed bench for qp_req_arbiter with a behavioural allocator model.
module tb_qp_req_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  cli_vld = '0;
    logic [3:0]  cli_rdy;
    logic [7:0]  cli_func = '0;
    logic [23:0] cli_size = '0;
    logic [39:0] cli_data = '0;
    logic [3:0]  rsp_vld;
    logic        rsp_err;
    logic [9:0]  rsp_data;
    logic        req_id;
    logic [1:0]  req_func;
    logic [5:0]  req_size;
    logic [9:0]  req_ddata;
    logic        busy;
    logic        av;
    logic        dv;
    logic [9:0]  rdata;
    logic        idle;

    int          m_len = 3;
    bit          m_ok = 1'b1;
    logic [9:0]  m_data = '0;
    bit          m_never = 1'b0;

    int          tests = 0;
    int          fails = 0;
    logic        exp_id = 1'b0;

    typedef struct {
        logic [3:0]  vld;
        logic [7:0]  func;
        logic [23:0] size;
        logic [39:0] data;
        int          len;
        bit          ok;
        logic [9:0]  rdata;
        logic [3:0]  e_vld;
        bit          e_err;
        logic [9:0]  e_data;
        bit          issued;
        logic [5:0]  e_size;
        logic [9:0]  e_ddata;
    } vec_t;

    vec_t vecs [10];

    qp_req_arbiter #(
        .NUM_CLI(4), .REQ_W(6), .REP_W(10), .START_TO(8)
    ) dut (
        .i_clk              (clk),
        .i_reset            (rst),
        .i_cli_req_vld      (cli_vld),
        .o_cli_req_rdy      (cli_rdy),
        .i_cli_req_func     (cli_func),
        .i_cli_req_size     (cli_size),
        .i_cli_req_data     (cli_data),
        .o_cli_rsp_vld      (rsp_vld),
        .o_cli_rsp_err      (rsp_err),
        .o_cli_rsp_data     (rsp_data),
        .o_req_id           (req_id),
        .o_req_func         (req_func),
        .o_req_alloc_size   (req_size),
        .o_req_dealloc_data (req_ddata),
        .i_busy             (busy),
        .i_rep_alloc_vld    (av),
        .i_rep_dealloc_vld  (dv),
        .i_rep_data         (rdata),
        .o_idle             (idle)
    );

    always #5 clk = ~clk;

    // Allocator: busy for m_len cycles after each id toggle, strobe on fall.
    initial begin : model
        logic       last;
        logic [1:0] f;
        busy = 0; av = 0; dv = 0; rdata = '0; last = 0;
        forever begin
            @(negedge clk);
            av = 0;
            dv = 0;
            if (rst) begin
                busy = 0;
                last = 0;
            end else if (req_id != last) begin
                last = req_id;
                f = req_func;
                if (!m_never) begin
                    busy = 1;
                    for (int k = 0; k < m_len && !rst; k++) @(negedge clk);
                    busy = 0;
                    if (rst) begin
                        last = 0;
                    end else begin
                        rdata = m_data;
                        if (m_ok) begin
                            if (f == 2'b01) av = 1;
                            else            dv = 1;
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic run_op(input logic [3:0] v, input logic [7:0] f,
                          input logic [23:0] s, input logic [39:0] d,
                          output logic [3:0] g_rdy, output logic [3:0] g_vld,
                          output logic g_err, output logic [9:0] g_data,
                          output int lat, output bit to);
        bit acc;
        acc = 0; g_rdy = '0; g_vld = '0; g_err = 0; g_data = '0;
        lat = 0; to = 1;
        @(negedge clk);
        cli_vld = v; cli_func = f; cli_size = s; cli_data = d;
        #1;
        for (int k = 0; k < 60; k++) begin
            if (!acc && |(cli_rdy & cli_vld)) begin
                acc = 1;
                g_rdy = cli_rdy;
            end
            if (rsp_vld != '0) begin
                g_vld = rsp_vld; g_err = rsp_err; g_data = rsp_data;
                to = 0;
                break;
            end
            @(negedge clk);
            if (acc) begin
                cli_vld = '0;
                lat++;
            end
            #1;
        end
        cli_vld = '0;
    endtask

    initial begin : main
        logic [3:0] g_rdy, g_vld;
        logic       g_err;
        logic [9:0] g_data;
        int         lat;
        bit         to;
        bit         seen;

        vecs[0] = '{4'b0100, 8'h10, 24'(16) << 12, 40'h0, 3, 1'b1, 10'h0A4,
                    4'b0100, 1'b0, 10'h0A4, 1'b1, 6'd16, 10'h0};
        vecs[1] = '{4'b0010, 8'h04, 24'h0, 40'h0, 2, 1'b1, 10'h0,
                    4'b0010, 1'b1, 10'h0, 1'b0, 6'd0, 10'h0};
        vecs[2] = '{4'b0010, 8'h0C, 24'(16) << 6, 40'h0, 2, 1'b1, 10'h0,
                    4'b0010, 1'b1, 10'h0, 1'b0, 6'd0, 10'h0};
        vecs[3] = '{4'b0001, 8'h01, 24'd32, 40'h0, 2, 1'b0, 10'h155,
                    4'b0001, 1'b1, 10'h155, 1'b1, 6'd32, 10'h0};
        vecs[4] = '{4'b1000, 8'h40, 24'(33) << 18, 40'h0, 2, 1'b1, 10'h0,
                    4'b1000, 1'b1, 10'h0, 1'b0, 6'd0, 10'h0};
        vecs[5] = '{4'b1000, 8'h80, 24'h0, 40'(10'h3FF) << 30, 2, 1'b1,
                    10'h2F0, 4'b1000, 1'b0, 10'h2F0, 1'b1, 6'd0, 10'h3FF};
        vecs[6] = '{4'b0110, 8'h28, 24'h0,
                    (40'(10'h011) << 10) | (40'(10'h022) << 20), 4, 1'b1,
                    10'h011, 4'b0010, 1'b0, 10'h011, 1'b1, 6'd0, 10'h011};
        vecs[7] = '{4'b0011, 8'h05, 24'd5 | (24'd7 << 6), 40'h0, 2, 1'b1,
                    10'h222, 4'b0001, 1'b0, 10'h222, 1'b1, 6'd5, 10'h0};
        vecs[8] = '{4'b0100, 8'h00, 24'h0, 40'h0, 2, 1'b1, 10'h0,
                    4'b0100, 1'b1, 10'h0, 1'b0, 6'd0, 10'h0};
        vecs[9] = '{4'b0001, 8'h02, 24'h0, 40'h123, 3, 1'b0, 10'h0F0,
                    4'b0001, 1'b1, 10'h0F0, 1'b1, 6'd0, 10'h123};

        repeat (2) @(negedge clk);
        #1;
        chk("reset rdy", cli_rdy, 0);
        chk("reset rsp_vld", rsp_vld, 0);
        chk("reset rsp_err", rsp_err, 0);
        chk("reset rsp_data", rsp_data, 0);
        chk("reset req_id", req_id, 0);
        chk("reset req_func", req_func, 0);
        chk("reset idle", idle, 1);
        rst = 0;

        for (int i = 0; i < 10; i++) begin
            m_len = vecs[i].len; m_ok = vecs[i].ok;
            m_data = vecs[i].rdata; m_never = 0;
            run_op(vecs[i].vld, vecs[i].func, vecs[i].size, vecs[i].data,
                   g_rdy, g_vld, g_err, g_data, lat, to);
            chk($sformatf("v%0d no_rsp", i), to, 0);
            chk($sformatf("v%0d rdy", i), g_rdy, vecs[i].e_vld);
            chk($sformatf("v%0d rsp_vld", i), g_vld, vecs[i].e_vld);
            chk($sformatf("v%0d err", i), g_err, vecs[i].e_err);
            chk($sformatf("v%0d data", i), g_data, vecs[i].e_data);
            chk($sformatf("v%0d req_func", i), req_func, 0);
            if (vecs[i].issued) begin
                exp_id = ~exp_id;
                chk($sformatf("v%0d size", i), req_size, vecs[i].e_size);
                chk($sformatf("v%0d ddata", i), req_ddata, vecs[i].e_ddata);
            end else begin
                chk($sformatf("v%0d rej_lat", i), lat, 1);
            end
            chk($sformatf("v%0d req_id", i), req_id, exp_id);
        end

        // Allocator never answers: timeout after START_TO cycles.
        m_never = 1;
        run_op(4'b0010, 8'h04, 24'(10) << 6, 40'h0,
               g_rdy, g_vld, g_err, g_data, lat, to);
        exp_id = ~exp_id;
        chk("to no_rsp", to, 0);
        chk("to latency", lat, 10);
        chk("to rsp_vld", g_vld, 4'b0010);
        chk("to err", g_err, 1);
        chk("to data", g_data, 0);
        chk("to req_func", req_func, 0);
        chk("to req_id", req_id, exp_id);
        m_never = 0; m_len = 2; m_ok = 1; m_data = 10'h321;
        run_op(4'b0010, 8'h08, 24'h0, 40'(10'h155) << 10,
               g_rdy, g_vld, g_err, g_data, lat, to);
        exp_id = ~exp_id;
        chk("post_to no_rsp", to, 0);
        chk("post_to rsp_vld", g_vld, 4'b0010);
        chk("post_to err", g_err, 0);
        chk("post_to data", g_data, 10'h321);
        chk("post_to ddata", req_ddata, 10'h155);
        chk("post_to req_id", req_id, exp_id);

        // Reset in the middle of WAIT_DONE.
        m_len = 8; m_ok = 1; m_data = 10'h3AA;
        @(negedge clk);
        cli_vld = 4'b0100; cli_func = 8'h10; cli_size = 24'(4) << 12;
        @(negedge clk);
        cli_vld = '0;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = busy;
        end
        chk("rst busy_seen", seen, 1);
        repeat (2) @(negedge clk);
        rst = 1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst2 rsp_vld", rsp_vld, 0);
        chk("rst2 rsp_err", rsp_err, 0);
        chk("rst2 rsp_data", rsp_data, 0);
        chk("rst2 req_id", req_id, 0);
        chk("rst2 req_func", req_func, 0);
        chk("rst2 req_size", req_size, 0);
        chk("rst2 ddata", req_ddata, 0);
        chk("rst2 idle", idle, 1);
        rst = 0;
        exp_id = 0;
        seen = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (rsp_vld != '0) seen = 1;
        end
        chk("rst2 no_rsp", seen, 0);

        // All four clients request continuously.
        m_len = 2; m_ok = 1; m_data = 10'h0C3;
        @(negedge clk);
        cli_vld = 4'hF; cli_func = 8'hAA; cli_size = '0;
        cli_data = 40'h12345_6789A;
        for (int n = 0; n < 5; n++) begin
            seen = 0;
            for (int k = 0; k < 40 && !seen; k++) begin
                @(negedge clk);
                #1;
                seen = (rsp_vld != '0);
            end
            exp_id = ~exp_id;
            chk($sformatf("rr%0d seen", n), seen, 1);
            chk($sformatf("rr%0d grant", n), rsp_vld, 4'(1) << (n % 4));
            chk($sformatf("rr%0d err", n), rsp_err, 0);
            chk($sformatf("rr%0d data", n), rsp_data, 10'h0C3);
            chk($sformatf("rr%0d req_id", n), req_id, exp_id);
            if (n == 4) cli_vld = '0;
            @(negedge clk);
            #1;
            chk($sformatf("rr%0d strobe_len", n), rsp_vld, 0);
        end
        @(negedge clk);
        #1;
        chk("end idle", idle, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
